// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU operation encodings, immediate formats.
package decode_stage_pkg;

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_BRANCH = 5'b01000;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // Raw 32-bit immediate; B and J forms carry an implicit zero LSB.
    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'h000};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Load scoreboard: one busy bit per register, plus the load-use hazard query for the
// instruction currently offered by fetch.
module decode_scoreboard
    import decode_stage_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int RA_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en_i,
    input  logic [RA_W-1:0] set_rd_i,
    input  logic            clr_en_i,
    input  logic [RA_W-1:0] clr_rd_i,
    input  logic            query_en_i,
    input  logic [RA_W-1:0] rs1_i,
    input  logic            rs1_used_i,
    input  logic [RA_W-1:0] rs2_i,
    input  logic            rs2_used_i,
    input  logic            inflight_load_i,
    input  logic [RA_W-1:0] inflight_rd_i,
    output logic            hazard_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             haz1_s;
    logic             haz2_s;

    // Busy update: clear first so that a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_rd_i] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (set_en_i) begin
            busy_d[set_rd_i] = 1'b1;
        end else begin
            busy_d[set_rd_i] = busy_d[set_rd_i];
        end
    end

    // Busy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A writeback to the busy register this cycle is forwarded, so it does not stall.
    always_comb begin
        haz1_s = rs1_used_i && (rs1_i != '0) &&
                 ((busy_q[rs1_i] && !(clr_en_i && (clr_rd_i == rs1_i))) ||
                  (inflight_load_i && (inflight_rd_i == rs1_i)));
        haz2_s = rs2_used_i && (rs2_i != '0) &&
                 ((busy_q[rs2_i] && !(clr_en_i && (clr_rd_i == rs2_i))) ||
                  (inflight_load_i && (inflight_rd_i == rs2_i)));
        hazard_o = query_en_i && (haz1_s || haz2_s);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RV32I decode stage with writeback forwarding and load-use stall.
// Optional RV32M decode of OP/funct7=0000001 is enabled by defining DECODE_MUL_EN.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int RA_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic [RA_W-1:0] rf_ra1,
    output logic [RA_W-1:0] rf_ra2,
    input  logic [XLEN-1:0] rf_qa,
    input  logic [XLEN-1:0] rf_qb,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [RA_W-1:0] out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_alu_op,
    output logic [XLEN-1:0] out_operand_a,
    output logic [XLEN-1:0] out_operand_b,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_offset,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_branch,
    output logic            out_load,
    output logic            out_store,
    output logic            out_we,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] operand_a;
        logic [XLEN-1:0] operand_b;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] offset;
        logic [RA_W-1:0] rd;
        logic [2:0]      funct3;
        logic [4:0]      alu_op;
        logic            jal;
        logic            jalr;
        logic            branch;
        logic            load;
        logic            store;
        logic            we;
        logic            illegal;
    } bundle_t;

    bundle_t         bundle_q;
    bundle_t         bundle_d;
    bundle_t         dec_s;
    logic            valid_q;
    logic            valid_d;
    logic [4:0]      opc_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [RA_W-1:0] rd_s;
    logic [RA_W-1:0] rs1_s;
    logic [RA_W-1:0] rs2_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic            rs1_used_s;
    logic            rs2_used_s;
    logic            legal_s;
    logic            writes_s;
    logic            hazard_s;
    logic            load_s;
    logic            sb_set_s;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'(signed'(v));
    endfunction

    function automatic logic [XLEN-1:0] src_val(input logic [RA_W-1:0] rs,
                                                input logic [XLEN-1:0] rf_q,
                                                input logic            wbv,
                                                input logic [RA_W-1:0] wbr,
                                                input logic [XLEN-1:0] wbd);
        logic [XLEN-1:0] v;
        if (rs == '0) begin
            v = '0;
        end else if (wbv && (wbr == rs)) begin
            v = wbd;
        end else begin
            v = rf_q;
        end
        return v;
    endfunction

    assign opc_s     = in_inst[6:2];
    assign funct3_s  = in_inst[14:12];
    assign funct7_s  = in_inst[31:25];
    assign rd_s      = in_inst[7 +: RA_W];
    assign rs1_s     = in_inst[15 +: RA_W];
    assign rs2_s     = in_inst[20 +: RA_W];
    assign rf_ra1    = rs1_s;
    assign rf_ra2    = rs2_s;
    assign rs1_val_s = src_val(rs1_s, rf_qa, wb_valid, wb_rd, wb_data);
    assign rs2_val_s = src_val(rs2_s, rf_qb, wb_valid, wb_rd, wb_data);

    // Instruction decode into the next output bundle.
    always_comb begin
        dec_s            = '0;
        dec_s.pc         = in_pc;
        dec_s.rd         = rd_s;
        dec_s.funct3     = funct3_s;
        dec_s.operand_a  = rs1_val_s;
        dec_s.store_data = rs2_val_s;
        rs1_used_s       = 1'b1;
        rs2_used_s       = 1'b0;
        legal_s          = 1'b1;
        writes_s         = 1'b0;
        case (opc_s)
            OPC_LUI: begin
                dec_s.operand_a = '0;
                dec_s.operand_b = sext(imm_gen(in_inst, IMM_U));
                rs1_used_s      = 1'b0;
                writes_s        = 1'b1;
            end
            OPC_AUIPC: begin
                dec_s.operand_a = in_pc;
                dec_s.operand_b = sext(imm_gen(in_inst, IMM_U));
                rs1_used_s      = 1'b0;
                writes_s        = 1'b1;
            end
            OPC_JAL: begin
                dec_s.operand_a = in_pc;
                dec_s.operand_b = XLEN'(32'd4);
                dec_s.offset    = sext(imm_gen(in_inst, IMM_J));
                dec_s.jal       = 1'b1;
                rs1_used_s      = 1'b0;
                writes_s        = 1'b1;
            end
            OPC_JALR: begin
                dec_s.operand_a = in_pc;
                dec_s.operand_b = XLEN'(32'd4);
                dec_s.offset    = sext(imm_gen(in_inst, IMM_I));
                dec_s.jalr      = 1'b1;
                writes_s        = 1'b1;
            end
            OPC_BRANCH: begin
                dec_s.operand_b = rs2_val_s;
                dec_s.offset    = sext(imm_gen(in_inst, IMM_B));
                dec_s.alu_op    = ALU_BRANCH;
                dec_s.branch    = 1'b1;
                rs2_used_s      = 1'b1;
            end
            OPC_LOAD: begin
                dec_s.operand_b = sext(imm_gen(in_inst, IMM_I));
                dec_s.load      = 1'b1;
                writes_s        = 1'b1;
            end
            OPC_STORE: begin
                dec_s.operand_b = sext(imm_gen(in_inst, IMM_S));
                dec_s.store     = 1'b1;
                rs2_used_s      = 1'b1;
            end
            OPC_OPIMM: begin
                // Shift-immediates hand the ALU the bare shamt, without the funct7 bits.
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    dec_s.operand_b = XLEN'(in_inst[24:20]);
                end else begin
                    dec_s.operand_b = sext(imm_gen(in_inst, IMM_I));
                end
                dec_s.alu_op = {1'b0, in_inst[30] & (funct3_s == 3'b101), funct3_s};
                writes_s     = 1'b1;
            end
            OPC_OP: begin
                dec_s.operand_b = rs2_val_s;
                rs2_used_s      = 1'b1;
                if (funct7_s == FUNCT7_MULDIV) begin
`ifdef DECODE_MUL_EN
                    dec_s.alu_op = {2'b10, funct3_s};
                    writes_s     = 1'b1;
`else
                    legal_s      = 1'b0;
`endif
                end else begin
                    dec_s.alu_op = {1'b0, in_inst[30], funct3_s};
                    writes_s     = 1'b1;
                end
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
        if (!legal_s || (in_inst[1:0] != 2'b11)) begin
            dec_s.illegal = 1'b1;
            dec_s.we      = 1'b0;
            dec_s.alu_op  = ALU_ADD;
            dec_s.jal     = 1'b0;
            dec_s.jalr    = 1'b0;
            dec_s.branch  = 1'b0;
            dec_s.load    = 1'b0;
            dec_s.store   = 1'b0;
        end else begin
            dec_s.we      = writes_s && (rd_s != '0);
        end
    end

    // A flushed load is dropped before execute sees it, so it must not mark its rd busy.
    assign sb_set_s = valid_q && out_ready && !flush && bundle_q.load && (bundle_q.rd != '0);

    decode_scoreboard #(
        .NREGS (NREGS),
        .RA_W  (RA_W)
    ) u_scoreboard (
        .clk             (clk),
        .rst             (rst),
        .set_en_i        (sb_set_s),
        .set_rd_i        (bundle_q.rd),
        .clr_en_i        (wb_valid),
        .clr_rd_i        (wb_rd),
        .query_en_i      (in_valid),
        .rs1_i           (rs1_s),
        .rs1_used_i      (rs1_used_s),
        .rs2_i           (rs2_s),
        .rs2_used_i      (rs2_used_s),
        .inflight_load_i (valid_q && bundle_q.load),
        .inflight_rd_i   (bundle_q.rd),
        .hazard_o        (hazard_s)
    );

    assign in_ready = (!valid_q || out_ready) && !hazard_s && !flush;
    assign load_s   = in_valid && in_ready;

    // Output register next state: flush beats load, load beats drain.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_s) begin
            valid_d  = 1'b1;
            bundle_d = dec_s;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_pc         = bundle_q.pc;
    assign out_rd         = bundle_q.rd;
    assign out_funct3     = bundle_q.funct3;
    assign out_alu_op     = bundle_q.alu_op;
    assign out_operand_a  = bundle_q.operand_a;
    assign out_operand_b  = bundle_q.operand_b;
    assign out_store_data = bundle_q.store_data;
    assign out_offset     = bundle_q.offset;
    assign out_jal        = bundle_q.jal;
    assign out_jalr       = bundle_q.jalr;
    assign out_branch     = bundle_q.branch;
    assign out_load       = bundle_q.load;
    assign out_store      = bundle_q.store;
    assign out_we         = bundle_q.we;
    assign out_illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; follows DECODE_MUL_EN like the RTL.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [4:0]  rf_ra1;
    logic [4:0]  rf_ra2;
    logic [31:0] rf_qa;
    logic [31:0] rf_qb;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_alu_op;
    logic [31:0] out_operand_a;
    logic [31:0] out_operand_b;
    logic [31:0] out_store_data;
    logic [31:0] out_offset;
    logic        out_jal;
    logic        out_jalr;
    logic        out_branch;
    logic        out_load;
    logic        out_store;
    logic        out_we;
    logic        out_illegal;

    int n_assert = 0;
    int n_fail   = 0;

    decode_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .rf_ra1         (rf_ra1),
        .rf_ra2         (rf_ra2),
        .rf_qa          (rf_qa),
        .rf_qb          (rf_qb),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_rd         (out_rd),
        .out_funct3     (out_funct3),
        .out_alu_op     (out_alu_op),
        .out_operand_a  (out_operand_a),
        .out_operand_b  (out_operand_b),
        .out_store_data (out_store_data),
        .out_offset     (out_offset),
        .out_jal        (out_jal),
        .out_jalr       (out_jalr),
        .out_branch     (out_branch),
        .out_load       (out_load),
        .out_store      (out_store),
        .out_we         (out_we),
        .out_illegal    (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = 32'h0; in_inst = 32'h0;
        rf_qa = 32'h0; rf_qb = 32'h0; wb_valid = 1'b0; wb_rd = 5'd0;
        wb_data = 32'h0; flush = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_valid", out_valid, 32'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_opa", out_operand_a, 32'h0);
        check("rst_alu", out_alu_op, 32'h0);
        check("rst_we", out_we, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // addi x1,x0,5
        in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h00500093; out_ready = 1'b1;
        #1 check("addi_in_ready", in_ready, 32'd1);
        step();
        check("addi_valid", out_valid, 32'd1);
        check("addi_opa", out_operand_a, 32'h0);
        check("addi_opb", out_operand_b, 32'd5);
        check("addi_alu", out_alu_op, 32'h00);
        check("addi_we", out_we, 32'd1);
        check("addi_rd", out_rd, 32'd1);
        check("addi_pc", out_pc, 32'h100);

        // srai x5,x1,3
        in_pc = 32'h104; in_inst = 32'h4030D293; rf_qa = 32'h80000000;
        step();
        check("srai_alu", out_alu_op, 32'h0D);
        check("srai_opb", out_operand_b, 32'd3);
        check("srai_opa", out_operand_a, 32'h80000000);
        check("srai_rd", out_rd, 32'd5);

        // lw x2,0(x1) then add x3,x2,x1 (load-use)
        in_pc = 32'h108; in_inst = 32'h0000A103; rf_qa = 32'h10;
        step();
        check("lw_load", out_load, 32'd1);
        check("lw_rd", out_rd, 32'd2);
        check("lw_opa", out_operand_a, 32'h10);
        check("lw_we", out_we, 32'd1);
        in_pc = 32'h10C; in_inst = 32'h001101B3; rf_qa = 32'hDEAD; rf_qb = 32'd7; out_ready = 1'b0;
        #1 check("lu_ready_held", in_ready, 32'd0);
        step();
        check("lu_load_held", out_load, 32'd1);
        check("lu_pc_held", out_pc, 32'h108);
        out_ready = 1'b1;
        #1 check("lu_ready_inflight", in_ready, 32'd0);
        step();
        check("lu_drain_valid", out_valid, 32'd0);
        check("lu_ready_busy1", in_ready, 32'd0);
        step();
        check("lu_ready_busy2", in_ready, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h1234;
        #1 check("lu_ready_wb", in_ready, 32'd1);
        step();
        wb_valid = 1'b0;
        check("add_valid", out_valid, 32'd1);
        check("add_opa_fwd", out_operand_a, 32'h1234);
        check("add_opb", out_operand_b, 32'd7);
        check("add_rd", out_rd, 32'd3);
        check("add_pc", out_pc, 32'h10C);

        // Hold a load for three cycles, then flush it
        in_pc = 32'h110; in_inst = 32'h0000A103; rf_qa = 32'h20;
        #1 check("lw2_ready", in_ready, 32'd1);
        step();
        check("lw2_load", out_load, 32'd1);
        out_ready = 1'b0; in_pc = 32'h114; in_inst = 32'h00500093;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_pc", out_pc, 32'h110);
            check("hold_opa", out_operand_a, 32'h20);
            check("hold_valid", out_valid, 32'd1);
            check("hold_ready", in_ready, 32'd0);
        end
        flush = 1'b1;
        #1 check("flush_ready", in_ready, 32'd0);
        step();
        flush = 1'b0;
        check("flush_valid", out_valid, 32'd0);
        in_pc = 32'h118; in_inst = 32'h001101B3; rf_qa = 32'h55; rf_qb = 32'd9;
        #1 check("flush_sb_clear", in_ready, 32'd1);
        out_ready = 1'b1;
        step();
        check("post_flush_valid", out_valid, 32'd1);
        check("post_flush_opa", out_operand_a, 32'h55);

        // mul x3,x1,x2
        in_pc = 32'h11C; in_inst = 32'h022081B3; rf_qa = 32'd3; rf_qb = 32'd4;
        step();
`ifdef DECODE_MUL_EN
        check("mul_alu", out_alu_op, 32'h10);
        check("mul_illegal", out_illegal, 32'd0);
        check("mul_we", out_we, 32'd1);
`else
        check("mul_alu", out_alu_op, 32'h00);
        check("mul_illegal", out_illegal, 32'd1);
        check("mul_we", out_we, 32'd0);
`endif

        // jal x1,+8
        in_pc = 32'h120; in_inst = 32'h008000EF;
        step();
        check("jal_flag", out_jal, 32'd1);
        check("jal_opa", out_operand_a, 32'h120);
        check("jal_opb", out_operand_b, 32'd4);
        check("jal_off", out_offset, 32'd8);
        check("jal_we", out_we, 32'd1);

        // beq x0,x0,-4
        in_pc = 32'h124; in_inst = 32'hFE000EE3;
        step();
        check("beq_flag", out_branch, 32'd1);
        check("beq_alu", out_alu_op, 32'h08);
        check("beq_off", out_offset, 32'hFFFFFFFC);
        check("beq_we", out_we, 32'd0);
        check("beq_illegal", out_illegal, 32'd0);

        // Unknown opcode, then a 16-bit-form encoding
        in_pc = 32'h128; in_inst = 32'h0000007F;
        step();
        check("badopc_illegal", out_illegal, 32'd1);
        check("badopc_we", out_we, 32'd0);
        check("badopc_valid", out_valid, 32'd1);
        in_pc = 32'h12C; in_inst = 32'h00500090;
        step();
        check("badlow_illegal", out_illegal, 32'd1);
        check("badlow_we", out_we, 32'd0);

        // Async reset while stalled on busy[2]
        in_pc = 32'h130; in_inst = 32'h0000A103; rf_qa = 32'h0;
        step();
        check("lw3_load", out_load, 32'd1);
        in_pc = 32'h134; in_inst = 32'h001101B3;
        step();
        check("rst_stall_ready", in_ready, 32'd0);
        check("rst_stall_pc", out_pc, 32'h130);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 32'd0);
        check("arst_pc", out_pc, 32'h0);
        check("arst_sb_clear", in_ready, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
